// File: rtl/arb_me_all_if.sv
// Interface for the N-to-1 ICB arbiter: upstream master bundle (i_bus_*) and downstream slave port (o_icb_*).
// With ARB_ME_LOCK_EN defined, adds the per-master cmd lock inputs and the merged lock output.
interface arb_me_all_if #(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int USR_W   = 1,
  parameter int ARB_NUM = 4
);
  logic [ARB_NUM-1:0]        i_bus_icb_cmd_vld;
  logic [ARB_NUM-1:0]        i_bus_icb_cmd_rdy;
  logic [ARB_NUM-1:0]        i_bus_icb_cmd_read;
  logic [ARB_NUM*AW-1:0]     i_bus_icb_cmd_addr;
  logic [ARB_NUM*DW-1:0]     i_bus_icb_cmd_wdata;
  logic [ARB_NUM*DW/8-1:0]   i_bus_icb_cmd_wmask;
  logic [ARB_NUM*USR_W-1:0]  i_bus_icb_cmd_usr;
  logic [ARB_NUM-1:0]        i_bus_icb_rsp_vld;
  logic [ARB_NUM-1:0]        i_bus_icb_rsp_rdy;
  logic [ARB_NUM-1:0]        i_bus_icb_rsp_err;
  logic [ARB_NUM*DW-1:0]     i_bus_icb_rsp_rdata;
  logic [ARB_NUM*USR_W-1:0]  i_bus_icb_rsp_usr;

  logic                      o_icb_cmd_vld;
  logic                      o_icb_cmd_rdy;
  logic                      o_icb_cmd_read;
  logic [AW-1:0]             o_icb_cmd_addr;
  logic [DW-1:0]             o_icb_cmd_wdata;
  logic [DW/8-1:0]           o_icb_cmd_wmask;
  logic [USR_W-1:0]          o_icb_cmd_usr;
  logic                      o_icb_rsp_vld;
  logic                      o_icb_rsp_rdy;
  logic                      o_icb_rsp_err;
  logic [DW-1:0]             o_icb_rsp_rdata;
  logic [USR_W-1:0]          o_icb_rsp_usr;

`ifdef ARB_ME_LOCK_EN
  logic [ARB_NUM-1:0]        i_bus_icb_cmd_lock;
  logic                      o_icb_cmd_lock;
`endif

  // Arbiter side
  modport slave (
`ifdef ARB_ME_LOCK_EN
    input  i_bus_icb_cmd_lock, output o_icb_cmd_lock,
`endif
    input  i_bus_icb_cmd_vld, output i_bus_icb_cmd_rdy, input i_bus_icb_cmd_read,
    input  i_bus_icb_cmd_addr, input i_bus_icb_cmd_wdata, input i_bus_icb_cmd_wmask,
    input  i_bus_icb_cmd_usr, output i_bus_icb_rsp_vld, input i_bus_icb_rsp_rdy,
    output i_bus_icb_rsp_err, output i_bus_icb_rsp_rdata, output i_bus_icb_rsp_usr,
    output o_icb_cmd_vld, input o_icb_cmd_rdy, output o_icb_cmd_read,
    output o_icb_cmd_addr, output o_icb_cmd_wdata, output o_icb_cmd_wmask,
    output o_icb_cmd_usr, input o_icb_rsp_vld, output o_icb_rsp_rdy,
    input  o_icb_rsp_err, input o_icb_rsp_rdata, input o_icb_rsp_usr
  );

  // Environment side: upstream masters plus the downstream slave
  modport master (
`ifdef ARB_ME_LOCK_EN
    output i_bus_icb_cmd_lock, input o_icb_cmd_lock,
`endif
    output i_bus_icb_cmd_vld, input i_bus_icb_cmd_rdy, output i_bus_icb_cmd_read,
    output i_bus_icb_cmd_addr, output i_bus_icb_cmd_wdata, output i_bus_icb_cmd_wmask,
    output i_bus_icb_cmd_usr, input i_bus_icb_rsp_vld, output i_bus_icb_rsp_rdy,
    input  i_bus_icb_rsp_err, input i_bus_icb_rsp_rdata, input i_bus_icb_rsp_usr,
    input  o_icb_cmd_vld, output o_icb_cmd_rdy, input o_icb_cmd_read,
    input  o_icb_cmd_addr, input o_icb_cmd_wdata, input o_icb_cmd_wmask,
    input  o_icb_cmd_usr, output o_icb_rsp_vld, input o_icb_rsp_rdy,
    output o_icb_rsp_err, output o_icb_rsp_rdata, output o_icb_rsp_usr
  );
endinterface

// File: rtl/arb_me_all.sv
// N-to-1 ICB arbiter/merger: round-robin cmd grant, grant FIFO steers in-order responses back.
// Optional ARB_ME_LOCK_EN: a master issuing lock=1 keeps the grant until its lock=0 handshake.
//
// state  | meaning
// S_FREE | grant follows round-robin pick each cycle
// S_HOLD | cmd offered but not accepted; grant frozen to owner_q until handshake
// S_LOCK | locked master owns the grant; rr pointer frozen
module arb_me_all #(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int USR_W   = 1,
  parameter int ARB_NUM = 4,
  parameter int FIFO_DP = 4
) (
  input  logic         clk,
  input  logic         rst,
  arb_me_all_if.slave  bus
);
  localparam int MW = DW/8;
  localparam int IW = $clog2(ARB_NUM);
  localparam int PW = (FIFO_DP > 1) ? $clog2(FIFO_DP) : 1;
  localparam int CW = $clog2(FIFO_DP+1);

  typedef enum logic [1:0] {S_FREE, S_HOLD, S_LOCK} state_e;

  state_e             state_q, state_d;
  logic [ARB_NUM-1:0] owner_q, owner_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [ARB_NUM-1:0] fifo_q [FIFO_DP];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [ARB_NUM-1:0] rr_gnt, gnt, head, lock_vec;
  logic [IW-1:0]      gnt_idx;
  logic               fifo_unfull, fifo_unempty, cmd_hsk, rsp_hsk, gnt_lock;
  logic               cmd_read;
  logic [AW-1:0]      cmd_addr;
  logic [DW-1:0]      cmd_wdata;
  logic [MW-1:0]      cmd_wmask;
  logic [USR_W-1:0]   cmd_usr;

  function automatic logic [ARB_NUM-1:0] rr_pick(input logic [ARB_NUM-1:0] req,
                                                 input logic [IW-1:0] ptr);
    logic [ARB_NUM-1:0] g;
    logic [IW-1:0]      k;
    g = '0;
    // Walk offsets downward so the closest requester to ptr is written last and wins
    for (int i = ARB_NUM-1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % ARB_NUM);
      if (req[k]) g = {{(ARB_NUM-1){1'b0}}, 1'b1} << k;
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DP-1)) ? '0 : p + 1'b1;
  endfunction

`ifdef ARB_ME_LOCK_EN
  assign lock_vec           = bus.i_bus_icb_cmd_lock;
  assign bus.o_icb_cmd_lock = gnt_lock;
`else
  assign lock_vec = '0;
`endif

  assign rr_gnt       = rr_pick(bus.i_bus_icb_cmd_vld, rr_q);
  assign gnt          = (state_q == S_FREE) ? rr_gnt : owner_q;
  assign gnt_lock     = |(lock_vec & gnt);
  assign fifo_unfull  = (cnt_q != CW'(FIFO_DP));
  assign fifo_unempty = (cnt_q != '0);
  assign head         = fifo_q[rd_ptr_q];

  assign bus.o_icb_cmd_vld     = |(bus.i_bus_icb_cmd_vld & gnt) & fifo_unfull;
  assign bus.i_bus_icb_cmd_rdy = gnt & {ARB_NUM{bus.o_icb_cmd_rdy & fifo_unfull}};
  assign cmd_hsk               = bus.o_icb_cmd_vld & bus.o_icb_cmd_rdy;

  always_comb begin
    cmd_read  = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    cmd_usr   = '0;
    gnt_idx   = '0;
    for (int k = 0; k < ARB_NUM; k++) begin
      cmd_read  |= gnt[k] & bus.i_bus_icb_cmd_read[k];
      cmd_addr  |= {AW{gnt[k]}}    & bus.i_bus_icb_cmd_addr[k*AW +: AW];
      cmd_wdata |= {DW{gnt[k]}}    & bus.i_bus_icb_cmd_wdata[k*DW +: DW];
      cmd_wmask |= {MW{gnt[k]}}    & bus.i_bus_icb_cmd_wmask[k*MW +: MW];
      cmd_usr   |= {USR_W{gnt[k]}} & bus.i_bus_icb_cmd_usr[k*USR_W +: USR_W];
      if (gnt[k]) gnt_idx = IW'(k);
    end
  end

  assign bus.o_icb_cmd_read  = cmd_read;
  assign bus.o_icb_cmd_addr  = cmd_addr;
  assign bus.o_icb_cmd_wdata = cmd_wdata;
  assign bus.o_icb_cmd_wmask = cmd_wmask;
  assign bus.o_icb_cmd_usr   = cmd_usr;

  assign bus.o_icb_rsp_rdy       = fifo_unempty & |(head & bus.i_bus_icb_rsp_rdy);
  assign bus.i_bus_icb_rsp_vld   = head & {ARB_NUM{bus.o_icb_rsp_vld & fifo_unempty}};
  assign bus.i_bus_icb_rsp_err   = {ARB_NUM{bus.o_icb_rsp_err}};
  assign bus.i_bus_icb_rsp_rdata = {ARB_NUM{bus.o_icb_rsp_rdata}};
  assign bus.i_bus_icb_rsp_usr   = {ARB_NUM{bus.o_icb_rsp_usr}};
  assign rsp_hsk                 = bus.o_icb_rsp_vld & bus.o_icb_rsp_rdy;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_FREE: begin
        if (cmd_hsk) begin
          owner_d = gnt;
          state_d = gnt_lock ? S_LOCK : S_FREE;
        end else if (bus.o_icb_cmd_vld) begin
          owner_d = gnt;
          state_d = S_HOLD;
        end
      end
      S_HOLD:  if (cmd_hsk) state_d = gnt_lock ? S_LOCK : S_FREE;
      S_LOCK:  if (cmd_hsk && !gnt_lock) state_d = S_FREE;
      default: state_d = S_FREE;
    endcase
    if (cmd_hsk && (state_q != S_LOCK))
      rr_d = (gnt_idx == IW'(ARB_NUM-1)) ? '0 : gnt_idx + 1'b1;
    if (cmd_hsk) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rsp_hsk) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({cmd_hsk, rsp_hsk})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_FREE;
      owner_q  <= '0;
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: head is only observed when the count is non-zero
  always_ff @(posedge clk) begin
    if (cmd_hsk) fifo_q[wr_ptr_q] <= gnt;
  end
endmodule

// File: tb/tb_arb_me_all.sv
// Self-checking bench for arb_me_all: directed scenarios then random traffic against a queue-based model.
module tb_arb_me_all;
  localparam int AW = 32, DW = 64, USR_W = 1, N = 4, DP = 2;

  logic clk, rst;
  int tests_run = 0, tests_failed = 0;

  arb_me_all_if #(.AW(AW), .DW(DW), .USR_W(USR_W), .ARB_NUM(N)) bus ();
  arb_me_all #(.AW(AW), .DW(DW), .USR_W(USR_W), .ARB_NUM(N), .FIFO_DP(DP)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Master-side stimulus (a raised request stays until its handshake)
  logic [N-1:0]    pend, m_rsp_rdy;
  logic            p_read [N], p_usr [N], p_lock [N];
  logic [AW-1:0]   p_addr [N];
  logic [DW-1:0]   p_wdata [N];
  logic [DW/8-1:0] p_wmask [N];
  logic            s_cmd_rdy, s_rsp_en, s_rsp_err;

  // Reference model: rr pointer, sticky owners and ordered outstanding list
  int            rr_m, hold_m, lock_m, exp_g;
  int            out_m [$];
  logic [AW-1:0] out_a [$];
  logic          exp_vld, exp_hsk, exp_rsp_hsk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] rsp_data(input logic [AW-1:0] a);
    return {32'h0, a ^ 32'h0000DFAD};
  endfunction

  function automatic int model_gnt();
    if (hold_m >= 0) return hold_m;
    if (lock_m >= 0) return lock_m;
    for (int i = 0; i < N; i++)
      if (pend[(rr_m + i) % N]) return (rr_m + i) % N;
    return -1;
  endfunction

  task automatic req(input int k, input logic rd, input logic [AW-1:0] a, input logic lk);
    pend[k]    = 1'b1;
    p_read[k]  = rd;
    p_addr[k]  = a;
    p_wdata[k] = {$urandom, $urandom};
    p_wmask[k] = 8'($urandom);
    p_usr[k]   = 1'($urandom);
    p_lock[k]  = lk;
  endtask

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      bus.i_bus_icb_cmd_vld[k]             = pend[k];
      bus.i_bus_icb_cmd_read[k]            = pend[k] & p_read[k];
      bus.i_bus_icb_cmd_addr[k*AW +: AW]   = pend[k] ? p_addr[k] : '0;
      bus.i_bus_icb_cmd_wdata[k*DW +: DW]  = pend[k] ? p_wdata[k] : '0;
      bus.i_bus_icb_cmd_wmask[k*8 +: 8]    = pend[k] ? p_wmask[k] : '0;
      bus.i_bus_icb_cmd_usr[k]             = pend[k] & p_usr[k];
`ifdef ARB_ME_LOCK_EN
      bus.i_bus_icb_cmd_lock[k]            = pend[k] & p_lock[k];
`endif
    end
    bus.i_bus_icb_rsp_rdy = m_rsp_rdy;
    bus.o_icb_cmd_rdy     = s_cmd_rdy;
    bus.o_icb_rsp_vld     = s_rsp_en && (out_a.size() > 0);
    bus.o_icb_rsp_err     = s_rsp_err;
    bus.o_icb_rsp_rdata   = (out_a.size() > 0) ? rsp_data(out_a[0]) : '0;
    bus.o_icb_rsp_usr     = (out_a.size() > 0) ? out_a[0][0] : 1'b0;
  endtask

  // Drive, settle, then check every output against the model
  task automatic step();
    logic unfull;
    int head;
    logic [105:0] exp_pl;
    apply();
    #1;
    exp_g   = model_gnt();
    unfull  = out_m.size() < DP;
    exp_vld = (exp_g >= 0) && pend[exp_g] && unfull;
    chk("cmd_vld", bus.o_icb_cmd_vld, exp_vld);
    chk("cmd_rdy", bus.i_bus_icb_cmd_rdy, (s_cmd_rdy && unfull) ? onehot(exp_g) : '0);
    exp_pl = '0;
    if (exp_g >= 0 && pend[exp_g])
      exp_pl = {p_read[exp_g], p_addr[exp_g], p_wdata[exp_g], p_wmask[exp_g], p_usr[exp_g]};
    chk("cmd_payload", {bus.o_icb_cmd_read, bus.o_icb_cmd_addr, bus.o_icb_cmd_wdata,
                        bus.o_icb_cmd_wmask, bus.o_icb_cmd_usr}, exp_pl);
`ifdef ARB_ME_LOCK_EN
    chk("cmd_lock", bus.o_icb_cmd_lock, (exp_g >= 0) && pend[exp_g] && p_lock[exp_g]);
`endif
    head = (out_m.size() > 0) ? out_m[0] : -1;
    chk("rsp_rdy", bus.o_icb_rsp_rdy, (head >= 0) && m_rsp_rdy[head]);
    chk("rsp_vld", bus.i_bus_icb_rsp_vld, (head >= 0 && s_rsp_en) ? onehot(head) : '0);
    if (head >= 0 && s_rsp_en)
      chk("rsp_rdata", bus.i_bus_icb_rsp_rdata[head*DW +: DW], rsp_data(out_a[0]));
    exp_hsk     = exp_vld && s_cmd_rdy;
    exp_rsp_hsk = (head >= 0) && s_rsp_en && m_rsp_rdy[head];
  endtask

  task automatic tick();
    @(posedge clk);
    if (exp_rsp_hsk) begin
      void'(out_m.pop_front());
      void'(out_a.pop_front());
    end
    if (exp_hsk) begin
      out_m.push_back(exp_g);
      out_a.push_back(p_addr[exp_g]);
      pend[exp_g] = 1'b0;
      if (lock_m < 0) rr_m = (exp_g + 1) % N;
      lock_m = p_lock[exp_g] ? exp_g : -1;
      hold_m = -1;
    end else if (exp_vld) begin
      hold_m = exp_g;
    end
    #1;
  endtask

  task automatic do_reset();
    pend = '0; m_rsp_rdy = '0;
    s_cmd_rdy = 1'b0; s_rsp_en = 1'b0; s_rsp_err = 1'b0;
    rst = 1'b0;
    apply();
    @(posedge clk);
    #1;
    out_m.delete(); out_a.delete();
    rr_m = 0; hold_m = -1; lock_m = -1;
    rst = 1'b1;
  endtask

  task automatic knobs_on();
    s_cmd_rdy = 1'b1; s_rsp_en = 1'b1; m_rsp_rdy = '1; s_rsp_err = 1'b0;
  endtask

  task automatic settle();
    knobs_on();
    for (int i = 0; i < 60; i++) begin
      if (pend == '0 && out_m.size() == 0) break;
      if (lock_m >= 0 && !pend[lock_m]) req(lock_m, 1'b0, 32'h0, 1'b0);
      step();
      tick();
    end
    chk("settle_done", (pend == '0) && (out_m.size() == 0), 1'b1);
  endtask

  initial begin
    logic [AW-1:0] a3;
    logic [N-1:0]  ord [4];
    for (int k = 0; k < N; k++) begin
      p_read[k] = 0; p_usr[k] = 0; p_lock[k] = 0; p_addr[k] = '0; p_wdata[k] = '0; p_wmask[k] = '0;
    end
    do_reset();
    do_reset();

    // Reset state and master 1 single read
    step();
    chk("reset_outs", {bus.o_icb_cmd_vld, bus.o_icb_rsp_rdy, bus.i_bus_icb_cmd_rdy, bus.i_bus_icb_rsp_vld}, '0);
    tick();
    s_cmd_rdy = 1'b1;
    req(1, 1'b1, 32'h100, 1'b0);
    step(); chk("m1_gnt", bus.i_bus_icb_cmd_rdy, 4'b0010); tick();
    s_rsp_en = 1'b1; m_rsp_rdy = '1;
    step();
    chk("m1_rsp_vld", bus.i_bus_icb_rsp_vld, 4'b0010);
    chk("m1_rdata", bus.i_bus_icb_rsp_rdata[DW +: DW], 64'hDEAD);
    chk("m1_err", bus.i_bus_icb_rsp_err[1], 1'b0);
    tick();
    for (int k = 0; k < N; k++) req(k, 1'b0, $urandom, 1'b0);
    step(); chk("rr_after_m1", bus.i_bus_icb_cmd_rdy, 4'b0100); tick();
    settle();

    // Masters 0 and 2 compete continuously
    do_reset(); knobs_on();
    ord[0] = 4'b0001; ord[1] = 4'b0100; ord[2] = 4'b0001; ord[3] = 4'b0100;
    req(0, 1'b1, $urandom, 1'b0); req(2, 1'b1, $urandom, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); chk("rr_order", bus.i_bus_icb_cmd_rdy, ord[i]); tick();
      if (!pend[0]) req(0, 1'b1, $urandom, 1'b0);
      if (!pend[2]) req(2, 1'b0, $urandom, 1'b0);
    end
    settle();

    // Grant hold while the slave stalls
    do_reset(); knobs_on(); s_cmd_rdy = 1'b0;
    req(3, 1'b0, 32'hA5A5_0300, 1'b0);
    a3 = p_addr[3];
    step(); chk("hold_vld", bus.o_icb_cmd_vld, 1'b1); tick();
    req(0, 1'b0, 32'h0000_0040, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_addr", bus.o_icb_cmd_addr, a3);
      chk("hold_no_rdy", bus.i_bus_icb_cmd_rdy, 4'b0000);
      tick();
    end
    s_cmd_rdy = 1'b1;
    step(); chk("hold_release", bus.i_bus_icb_cmd_rdy, 4'b1000); tick();
    step(); chk("after_hold", bus.i_bus_icb_cmd_rdy, 4'b0001); tick();
    settle();

    // FIFO full blocks cmds; a pop frees a slot only on the next cycle
    do_reset(); knobs_on(); s_rsp_en = 1'b0;
    for (int k = 0; k < 3; k++) req(k, 1'b1, $urandom, 1'b0);
    step(); chk("full_h0", bus.i_bus_icb_cmd_rdy, 4'b0001); tick();
    step(); chk("full_h1", bus.i_bus_icb_cmd_rdy, 4'b0010); tick();
    step(); chk("full_block", bus.o_icb_cmd_vld, 1'b0); tick();
    s_rsp_en = 1'b1;
    step(); chk("full_pop", bus.o_icb_rsp_rdy, 1'b1); chk("full_no_cut", bus.o_icb_cmd_vld, 1'b0); tick();
    step(); chk("full_refill", bus.i_bus_icb_cmd_rdy, 4'b0100); tick();
    settle();

    // Error response stalled by master 2's rsp_rdy
    do_reset(); knobs_on(); s_rsp_en = 1'b0;
    req(2, 1'b1, 32'h0000_2000, 1'b0);
    step(); tick();
    s_rsp_en = 1'b1; s_rsp_err = 1'b1; m_rsp_rdy = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("err_stall_rdy", bus.o_icb_rsp_rdy, 1'b0);
      chk("err_stall_vld", bus.i_bus_icb_rsp_vld, 4'b0100);
      tick();
    end
    m_rsp_rdy = 4'b1111;
    step(); chk("err_pop", bus.o_icb_rsp_rdy, 1'b1); chk("err_seen", bus.i_bus_icb_rsp_err[2], 1'b1); tick();
    step(); chk("err_done", bus.i_bus_icb_rsp_vld, 4'b0000); tick();
    settle();

    // Reset with two outstanding and rr pointing at master 1
    do_reset(); knobs_on(); s_rsp_en = 1'b0;
    req(2, 1'b1, $urandom, 1'b0); step(); tick();
    req(0, 1'b1, $urandom, 1'b0); step(); tick();
    do_reset(); knobs_on();
    req(0, 1'b1, $urandom, 1'b0); req(1, 1'b1, $urandom, 1'b0);
    step(); chk("rst_rsp_rdy", bus.o_icb_rsp_rdy, 1'b0); chk("rst_tie", bus.i_bus_icb_cmd_rdy, 4'b0001); tick();
    settle();

`ifdef ARB_ME_LOCK_EN
    // Locked sequence from master 1 keeps master 0 out
    do_reset(); knobs_on();
    req(1, 1'b0, $urandom, 1'b1);
    step(); chk("lock_c1", bus.i_bus_icb_cmd_rdy, 4'b0010); tick();
    req(1, 1'b0, $urandom, 1'b1); req(0, 1'b0, $urandom, 1'b0);
    step(); chk("lock_c2", bus.i_bus_icb_cmd_rdy, 4'b0010); tick();
    req(1, 1'b0, $urandom, 1'b0);
    step(); chk("lock_c3", bus.i_bus_icb_cmd_rdy, 4'b0010); tick();
    step(); chk("lock_free", bus.i_bus_icb_cmd_rdy, 4'b0001); tick();
    settle();
`endif

    // Random traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++)
        if (!pend[k] && $urandom_range(2) == 0) begin
`ifdef ARB_ME_LOCK_EN
          req(k, 1'($urandom), $urandom, $urandom_range(4) == 0);
`else
          req(k, 1'($urandom), $urandom, 1'b0);
`endif
        end
      s_cmd_rdy = ($urandom_range(3) != 0);
      s_rsp_en  = ($urandom_range(2) != 0);
      s_rsp_err = 1'($urandom);
      m_rsp_rdy = 4'($urandom);
      step();
      tick();
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/arb_me_all.md
Name: arb_me_all

Overview:
- N-to-1 ICB arbiter/merger; the converse of the splitter.
- ARB_NUM upstream ICB masters share one downstream ICB slave port.
- Round-robin command arbitration. Granted master index is recorded in an outstanding FIFO so in-order responses return to the issuing master.
- Sits in front of shared slaves such as the APB bridge or SRAM, where several masters converge.

Parameters:
- AW, 32, address width.
- DW, 64, data width; wmask width is DW/8.
- USR_W, 1, user sideband width.
- ARB_NUM, 4, number of upstream masters; must be at least 2.
- FIFO_DP, 4, max outstanding commands (grant FIFO depth); must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- i_bus_icb_cmd_vld  in  ARB_NUM  per-master cmd valid.
- i_bus_icb_cmd_rdy  out  ARB_NUM  per-master cmd ready.
- i_bus_icb_cmd_read  in  ARB_NUM  per-master read flag.
- i_bus_icb_cmd_addr  in  ARB_NUM*AW  packed addresses; master k at [(k+1)*AW-1:k*AW].
- i_bus_icb_cmd_wdata  in  ARB_NUM*DW  packed write data.
- i_bus_icb_cmd_wmask  in  ARB_NUM*DW/8  packed byte masks.
- i_bus_icb_cmd_usr  in  ARB_NUM*USR_W  packed cmd user bits.
- i_bus_icb_rsp_vld  out  ARB_NUM  per-master rsp valid.
- i_bus_icb_rsp_rdy  in  ARB_NUM  per-master rsp ready.
- i_bus_icb_rsp_err  out  ARB_NUM  per-master rsp error.
- i_bus_icb_rsp_rdata  out  ARB_NUM*DW  packed read data.
- i_bus_icb_rsp_usr  out  ARB_NUM*USR_W  packed rsp user bits.
- o_icb_cmd_vld  out  1  merged cmd valid.
- o_icb_cmd_rdy  in  1  slave cmd ready.
- o_icb_cmd_read  out  1  granted read flag.
- o_icb_cmd_addr  out  AW  granted address.
- o_icb_cmd_wdata  out  DW  granted write data.
- o_icb_cmd_wmask  out  DW/8  granted byte mask.
- o_icb_cmd_usr  out  USR_W  granted cmd user bits.
- o_icb_rsp_vld  in  1  slave rsp valid.
- o_icb_rsp_rdy  out  1  rsp ready to slave.
- o_icb_rsp_err  in  1  slave rsp error.
- o_icb_rsp_rdata  in  DW  slave read data.
- o_icb_rsp_usr  in  USR_W  slave rsp user bits.

Behaviour:
- Reset (rst=0 at a clk edge):
  - grant FIFO empty; rr pointer=0 (master 0 highest priority); hold flag clear.
  - All vld/rdy outputs 0 in that cycle and until valid stimulus.
- Arbitration (combinational grant, one-hot gnt):
  - Pick the first requesting master searching from the rr pointer upward, wrapping modulo ARB_NUM.
  - gnt=0 when no requests.
- Grant hold:
  - Set when o_icb_cmd_vld=1 and o_icb_cmd_rdy=0; the registered grant is used until handshake, so payload stays stable per ICB.
  - Cleared on handshake.
  - A held master dropping vld is a protocol violation; the design need not handle it.
- Cmd path:
  - o_icb_cmd_vld = |(i_vld & gnt) & fifo_unfull.
  - i_bus_icb_cmd_rdy[k] = gnt[k] & o_icb_cmd_rdy & fifo_unfull.
  - Payload is an AND-OR mux by gnt; all zero when gnt=0.
  - Zero-latency cmd pass-through; no registers in the cmd data path.
- RR update: on a cmd handshake by master k, rr pointer <= (k+1) mod ARB_NUM; otherwise unchanged.
- Grant FIFO:
  - Push gnt on cmd handshake; pop on rsp handshake.
  - Full means FIFO_DP entries; cmd_vld is blocked and no cut-through on a same-cycle pop (ready cut).
  - Simultaneous push and pop while not full or empty keeps the count.
- Rsp path, head = FIFO output:
  - o_icb_rsp_rdy = fifo_unempty & |(head & i_bus_icb_rsp_rdy).
  - i_bus_icb_rsp_vld[k] = head[k] & o_icb_rsp_vld & fifo_unempty.
  - err/rdata/usr are broadcast to all masters, qualified only by vld.
  - Empty FIFO: o_icb_rsp_rdy=0; no zero-cycle response allowed; the slave responds at least 1 cycle after the cmd handshake.
- Ordering: responses are strictly in cmd order; the slave must be in-order.
- Reset mid-operation: outstanding entries are discarded and the rr pointer returns to 0; the slave is reset alongside.

Optional Feature:
- ARB_ME_LOCK_EN defined:
  - Extra input i_bus_icb_cmd_lock [ARB_NUM] and output o_icb_cmd_lock.
  - After a handshake with lock=1 from master k, gnt is forced to k for all later cmds until a handshake by k with lock=0.
  - Other masters see rdy=0 meanwhile.
  - rr pointer is frozen while locked.
- Not defined: no lock ports; pure round-robin.

Test Plan:
- Master 1 alone reads addr 0x100, slave returns rdata 0xDEAD, err=0 one cycle later -> only i_bus_icb_rsp_vld[1]=1; rdata slice 1 = 0xDEAD; rr pointer becomes 2.
- Masters 0 and 2 request every cycle, slave always ready -> grant order 0,2,0,2; each response routed to the matching master.
- Master 3 granted with o_icb_cmd_rdy=0 for 3 cycles while master 0 raises vld -> addr/wdata of master 3 stay stable; master 0 granted only after master 3's handshake.
- FIFO_DP=2, 3 masters request, slave withholds rsp -> 2 cmd handshakes, then o_icb_cmd_vld=0. One rsp handshake -> third cmd issued next cycle, not the same cycle.
- Response with err=1 while head=master 2 and i_bus_icb_rsp_rdy[2]=0 -> o_icb_rsp_rdy=0 and the FIFO holds. rdy[2]=1 -> pop and err seen by master 2.
- rst=0 with 2 outstanding -> next cycle FIFO empty, o_icb_rsp_rdy=0, master 0 wins a 0/1 tie.
- With ARB_ME_LOCK_EN: master 1 sends lock=1, lock=1, lock=0 while master 0 requests -> master 0 is granted only after the third cmd.
